vgacon_tty_ctrl: RTL and testbench

VGACON_TTY_CTRL -- requirements
Module: vgacon_tty_ctrl

---
 rtl/vgacon_pkg.sv | 27 ++
 rtl/vgacon_cursor.sv | 49 ++++
 rtl/vgacon_tty_ctrl.sv | 169 ++++++++++++++++
 tb/tb_vgacon_tty_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vgacon_pkg.sv
// Shared constants, state encoding and helpers for the VGA text console controller.
// The optional vblank write gating is selected with VGACON_VBLANK_WRITE_EN in vgacon_tty_ctrl.
package vgacon_pkg;

    localparam int NUM_ROWS  = 3;
    localparam int NUM_COLS  = 10;
    localparam int NUM_CHARS = NUM_ROWS * NUM_COLS;

    localparam logic [6:0] CHAR_SPACE = 7'h20;
    localparam logic [6:0] CR         = 7'h0D;
    localparam logic [6:0] LF         = 7'h0A;
    localparam logic [6:0] BS         = 7'h08;
    localparam logic [6:0] FF         = 7'h0C;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        SCROLL_COPY,
        SCROLL_FILL,
        CLEAR
    } state_t;

    function automatic logic is_printable(input logic [6:0] code);
        return (code >= 7'h20) && (code <= 7'h7E);
    endfunction

endpackage

// File: rtl/vgacon_cursor.sv
// Cursor position registers for the text console: advance with wrap, CR, LF, BS and home.
// Wrap/overflow flags let the controller decide when a scroll is needed.
module vgacon_cursor
    import vgacon_pkg::*;
#(
    parameter int ROWS = NUM_ROWS,
    parameter int COLS = NUM_COLS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       home,
    input  logic       advance,
    input  logic       cr,
    input  logic       lf,
    input  logic       bs,
    output logic [1:0] row,
    output logic [3:0] col,
    output logic       at_last_col,
    output logic       at_last_row
);

    assign at_last_col = (col == 4'(COLS - 1));
    assign at_last_row = (row == 2'(ROWS - 1));

    // On the last row the row index saturates; the controller scrolls the text instead.
    always_ff @(posedge clk) begin
        if (rst || home) begin
            row <= '0;
            col <= '0;
        end else if (advance) begin
            if (at_last_col) begin
                col <= '0;
                if (!at_last_row)
                    row <= row + 2'd1;
            end else begin
                col <= col + 4'd1;
            end
        end else if (cr) begin
            col <= '0;
        end else if (lf) begin
            if (!at_last_row)
                row <= row + 2'd1;
        end else if (bs) begin
            if (col != '0)
                col <= col - 4'd1;
        end
    end

endmodule

// File: rtl/vgacon_tty_ctrl.sv
// Teletype-style controller that writes characters into a VGA text buffer, with scroll and clear.
// Define VGACON_VBLANK_WRITE_EN to restrict buffer writes to the vblank window.
module vgacon_tty_ctrl #(
    parameter int NUM_ROWS = 3,
    parameter int NUM_COLS = 10,
    parameter int COLOR_W  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [6:0]         in_char,
    input  logic [COLOR_W-1:0] in_color,
    input  logic               vblank,
    output logic               buf_we,
    output logic [4:0]         buf_addr,
    output logic [COLOR_W+6:0] buf_wdata,
    output logic [4:0]         buf_raddr,
    input  logic [COLOR_W+6:0] buf_rdata,
    output logic [1:0]         cursor_row,
    output logic [3:0]         cursor_col,
    output logic               busy,
    output logic               scroll_irq
);
    import vgacon_pkg::*;

    localparam int CELLS = NUM_ROWS * NUM_COLS;
    localparam logic [4:0] LAST_CELL = 5'(CELLS - 1);
    localparam logic [4:0] LAST_COPY = 5'(CELLS - NUM_COLS - 1);

    state_t             state, next_state;
    logic [4:0]         idx;
    logic [6:0]         char_q;
    logic [COLOR_W-1:0] color_q;
    logic               gate;
    logic               cur_home, cur_adv, cur_cr, cur_lf, cur_bs;
    logic               at_last_col, at_last_row;

`ifdef VGACON_VBLANK_WRITE_EN
    assign gate = vblank;
`else
    logic unused_vblank;
    assign unused_vblank = vblank;
    assign gate          = 1'b1;
`endif

    vgacon_cursor #(
        .ROWS (NUM_ROWS),
        .COLS (NUM_COLS)
    ) u_cursor (
        .clk         (clk),
        .rst         (rst),
        .home        (cur_home),
        .advance     (cur_adv),
        .cr          (cur_cr),
        .lf          (cur_lf),
        .bs          (cur_bs),
        .row         (cursor_row),
        .col         (cursor_col),
        .at_last_col (at_last_col),
        .at_last_row (at_last_row)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    // The cell index runs straight from the copy range into the fill range.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx <= '0;
        end else if (state == SCROLL_COPY || state == SCROLL_FILL || state == CLEAR) begin
            if (gate)
                idx <= (idx == LAST_CELL) ? 5'd0 : idx + 5'd1;
        end else begin
            idx <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            char_q     <= '0;
            color_q    <= '0;
            scroll_irq <= 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                char_q  <= in_char;
                color_q <= in_color;
            end
            scroll_irq <= (state == SCROLL_FILL) && gate && (idx == LAST_CELL);
        end
    end

    // Control codes act on the cursor in the handshake cycle itself.
    always_comb begin
        next_state = state;
        cur_home   = 1'b0;
        cur_adv    = 1'b0;
        cur_cr     = 1'b0;
        cur_lf     = 1'b0;
        cur_bs     = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    if (is_printable(in_char)) begin
                        next_state = WRITE;
                    end else begin
                        case (in_char)
                            CR: cur_cr = 1'b1;
                            LF: begin
                                cur_lf = 1'b1;
                                if (at_last_row)
                                    next_state = SCROLL_COPY;
                            end
                            BS: cur_bs = 1'b1;
                            FF: begin
                                cur_home   = 1'b1;
                                next_state = CLEAR;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            WRITE: begin
                if (gate) begin
                    cur_adv    = 1'b1;
                    next_state = (at_last_col && at_last_row) ? SCROLL_COPY : IDLE;
                end
            end
            SCROLL_COPY: if (gate && idx == LAST_COPY) next_state = SCROLL_FILL;
            SCROLL_FILL: if (gate && idx == LAST_CELL) next_state = IDLE;
            CLEAR:       if (gate && idx == LAST_CELL) next_state = IDLE;
            default:     next_state = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        busy      = (state != IDLE);
        buf_we    = 1'b0;
        buf_addr  = '0;
        buf_wdata = '0;
        buf_raddr = '0;
        case (state)
            WRITE: begin
                buf_we    = gate;
                buf_addr  = 5'(cursor_row) * 5'(NUM_COLS) + 5'(cursor_col);
                buf_wdata = {color_q, char_q};
            end
            SCROLL_COPY: begin
                buf_we    = gate;
                buf_addr  = idx;
                buf_raddr = idx + 5'(NUM_COLS);
                buf_wdata = buf_rdata;
            end
            SCROLL_FILL, CLEAR: begin
                buf_we    = gate;
                buf_addr  = idx;
                buf_wdata = {{COLOR_W{1'b0}}, CHAR_SPACE};
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_vgacon_tty_ctrl.sv
// Self-checking bench for vgacon_tty_ctrl: directed and random character streams against a text-screen model.
// Honours VGACON_VBLANK_WRITE_EN when the design is built with it.
module tb_vgacon_tty_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [6:0] in_char;
    logic [1:0] in_color;
    logic       vblank;
    logic       buf_we;
    logic [4:0] buf_addr;
    logic [8:0] buf_wdata;
    logic [4:0] buf_raddr;
    logic [8:0] buf_rdata;
    logic [1:0] cursor_row;
    logic [3:0] cursor_col;
    logic       busy;
    logic       scroll_irq;

    logic [8:0] mem       [0:31];
    logic [8:0] model_mem [0:31];
    int         mrow, mcol;

    int checks = 0;
    int errors = 0;
    int n_writes, n_busy, n_irq, n_irq_timed;
    logic last29 = 1'b0;

    vgacon_tty_ctrl #(
        .NUM_ROWS (3),
        .NUM_COLS (10),
        .COLOR_W  (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_char    (in_char),
        .in_color   (in_color),
        .vblank     (vblank),
        .buf_we     (buf_we),
        .buf_addr   (buf_addr),
        .buf_wdata  (buf_wdata),
        .buf_raddr  (buf_raddr),
        .buf_rdata  (buf_rdata),
        .cursor_row (cursor_row),
        .cursor_col (cursor_col),
        .busy       (busy),
        .scroll_irq (scroll_irq)
    );

    always #5 clk = ~clk;

    // Behavioural text buffer with a combinational read port.
    assign buf_rdata = mem[buf_raddr];

    always @(posedge clk) begin
        if (scroll_irq) begin
            n_irq++;
            if (last29) n_irq_timed++;
        end
        last29 = buf_we && (buf_addr == 5'd29);
        if (busy) n_busy++;
        if (buf_we) begin
            n_writes++;
            mem[buf_addr] <= buf_wdata;
        end
    end

`ifndef VGACON_VBLANK_WRITE_EN
    always @(negedge clk) vblank = 1'($urandom_range(0, 1));
`endif

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic model_scroll();
        for (int k = 0; k < 20; k++) model_mem[k] = model_mem[k + 10];
        for (int k = 20; k < 30; k++) model_mem[k] = 9'h020;
    endtask

    // Screen model: what a teletype does to a 3x10 page for one received code.
    task automatic model_apply(input logic [6:0] ch, input logic [1:0] c, output int exp_w, output int exp_irq);
        exp_w   = 0;
        exp_irq = 0;
        if (ch >= 7'h20 && ch <= 7'h7E) begin
            model_mem[mrow * 10 + mcol] = {c, ch};
            exp_w = 1;
            if (mcol < 9) begin
                mcol++;
            end else begin
                mcol = 0;
                if (mrow < 2) mrow++;
                else begin model_scroll(); exp_w += 30; exp_irq = 1; end
            end
        end else if (ch == 7'h0D) begin
            mcol = 0;
        end else if (ch == 7'h0A) begin
            if (mrow < 2) mrow++;
            else begin model_scroll(); exp_w = 30; exp_irq = 1; end
        end else if (ch == 7'h08) begin
            if (mcol > 0) mcol--;
        end else if (ch == 7'h0C) begin
            for (int k = 0; k < 30; k++) model_mem[k] = 9'h020;
            mrow  = 0;
            mcol  = 0;
            exp_w = 30;
        end
    endtask

    task automatic check_mem(input string tag);
        int bad = 0;
        for (int k = 0; k < 30; k++) if (mem[k] !== model_mem[k]) bad++;
        checkOutput(tag, bad, 0);
    endtask

    task automatic applyStimulus(input logic [6:0] ch, input logic [1:0] c);
        int guard = 0;
        @(negedge clk);
        n_writes    = 0;
        n_busy      = 0;
        n_irq       = 0;
        n_irq_timed = 0;
        in_valid    = 1'b1;
        in_char     = ch;
        in_color    = c;
        @(negedge clk);
        in_valid = 1'b0;
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("done_timeout", 32'(guard < 200), 1);
        @(negedge clk);
    endtask

    task automatic send_and_check(input string tag, input logic [6:0] ch, input logic [1:0] c);
        int exp_w, exp_irq;
        model_apply(ch, c, exp_w, exp_irq);
        applyStimulus(ch, c);
        checkOutput({tag, "_row"}, cursor_row, mrow);
        checkOutput({tag, "_col"}, cursor_col, mcol);
        checkOutput({tag, "_writes"}, n_writes, exp_w);
        checkOutput({tag, "_busy"}, n_busy, exp_w);
        checkOutput({tag, "_irq"}, n_irq, exp_irq);
        if (exp_irq == 1) checkOutput({tag, "_irq_timing"}, n_irq_timed, 1);
        check_mem({tag, "_mem"});
    endtask

    function automatic logic [6:0] random_code();
        int r = $urandom_range(0, 9);
        logic [6:0] v;
        case (r)
            5: v = 7'h0D;
            6: v = 7'h0A;
            7: v = 7'h08;
            8: v = 7'h0C;
            9: v = ($urandom_range(0, 1) == 0) ? 7'h7F : 7'h1B;
            default: v = 7'($urandom_range(32, 126));
        endcase
        return v;
    endfunction

    initial begin
        int guard;
        for (int k = 0; k < 32; k++) begin
            mem[k]       = '0;
            model_mem[k] = '0;
        end
        mrow     = 0;
        mcol     = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_char  = '0;
        in_color = '0;
`ifdef VGACON_VBLANK_WRITE_EN
        vblank = 1'b1;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_ready", in_ready, 1);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_we", buf_we, 0);
        checkOutput("rst_irq", scroll_irq, 0);
        checkOutput("rst_row", cursor_row, 0);
        checkOutput("rst_col", cursor_col, 0);
        rst = 1'b0;

        send_and_check("char_A", 7'h41, 2'd1);
        checkOutput("char_A_cell", mem[0], 9'h0C1);

        send_and_check("cr", 7'h0D, 2'd0);
        for (int k = 0; k < 10; k++) send_and_check("line", 7'(7'h30 + k), 2'(k));
        send_and_check("bs_col0", 7'h08, 2'd0);
        send_and_check("bell", 7'h07, 2'd3);
        send_and_check("lf", 7'h0A, 2'd0);
        for (int k = 0; k < 4; k++) send_and_check("row2", 7'(7'h61 + k), 2'd2);
        send_and_check("lf_scroll", 7'h0A, 2'd0);
        send_and_check("clear", 7'h0C, 2'd0);

        for (int n = 0; n < 60; n++) send_and_check("rand", random_code(), 2'($urandom_range(0, 3)));

        // Abort a scroll partway through the copy.
        while (mrow < 2) send_and_check("to_last", 7'h0A, 2'd0);
        @(negedge clk);
        in_valid = 1'b1;
        in_char  = 7'h0A;
        in_color = 2'd0;
        @(negedge clk);
        in_valid = 1'b0;
        guard = 0;
        while (!(buf_we && buf_addr == 5'd7) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("abort_reach", 32'(guard < 100), 1);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_ready", in_ready, 1);
        checkOutput("abort_we", buf_we, 0);
        checkOutput("abort_row", cursor_row, 0);
        checkOutput("abort_col", cursor_col, 0);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) model_mem[k] = model_mem[k + 10];
        mrow = 0;
        mcol = 0;
        check_mem("abort_mem");
        send_and_check("after_abort", 7'h5A, 2'd2);

`ifdef VGACON_VBLANK_WRITE_EN
        begin
            int exp_w, exp_irq;
            vblank = 1'b0;
            model_apply(7'h0C, 2'd0, exp_w, exp_irq);
            @(negedge clk);
            n_writes = 0;
            in_valid = 1'b1;
            in_char  = 7'h0C;
            @(negedge clk);
            in_valid = 1'b0;
            repeat (8) @(negedge clk);
            checkOutput("hold_writes", n_writes, 0);
            checkOutput("hold_busy", busy, 1);
            vblank = 1'b1;
            guard = 0;
            while (!in_ready && guard < 100) begin
                @(negedge clk);
                guard++;
            end
            checkOutput("hold_done", 32'(guard < 100), 1);
            @(negedge clk);
            check_mem("hold_mem");
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
